// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier and its divider sibling:
// controller state encoding and the iteration-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } mult_state_t;

  // Counter must hold 0..width-1; a 1-bit counter is the floor.
  function automatic int mult_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/twos_magnitude.sv
// Splits a two's-complement value into its unsigned magnitude and sign bit.
// The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
module twos_magnitude #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  assign sign      = value[WIDTH-1];
  assign magnitude = sign ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/booth_free_multiplier_module.sv
// Sequential signed WIDTH x WIDTH multiplier: magnitude shift-and-add, then sign fix.
// Optional MULT_EARLY_TERM_EN ends the add loop once the remaining multiplier bits are zero.
module booth_free_multiplier_module
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Start_Sig,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy_Sig,
  output logic                 Done_Sig,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CNT_W = mult_cnt_w(WIDTH);
  localparam int PW    = 2 * WIDTH;

  mult_state_t        state_reg;
  logic [WIDTH-1:0]   ma_reg;
  logic [WIDTH-1:0]   mb_reg;
  logic               neg_reg;
  logic [PW-1:0]      acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [PW-1:0]      product_reg;

  logic [WIDTH-1:0]   operand [2];
  logic [WIDTH-1:0]   mag     [2];
  logic               sign    [2];

  logic [PW-1:0]      addend;
  logic [PW-1:0]      acc_next;
  logic [WIDTH-1:0]   mb_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               last_iter;
  logic               skip_mul;
  logic               neg_next;

  assign operand[0] = Multiplicand;
  assign operand[1] = Multiplier;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mag
      twos_magnitude #(.WIDTH(WIDTH)) u_mag (
        .value     (operand[gi]),
        .magnitude (mag[gi]),
        .sign      (sign[gi])
      );
    end
  endgenerate

  always_comb begin
    addend    = PW'(ma_reg) << cnt_reg;
    acc_next  = mb_reg[0] ? (acc_reg + addend) : acc_reg;
    mb_next   = mb_reg >> 1;
    cnt_next  = cnt_reg + CNT_W'(1);
    last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
    skip_mul  = 1'b0;
`ifdef MULT_EARLY_TERM_EN
    last_iter = last_iter || (mb_next == '0);
    skip_mul  = (mag[1] == '0);
`endif
    // A zero operand never yields a negative result, so no -0 artefacts.
    neg_next  = (sign[0] ^ sign[1]) && (mag[0] != '0) && (mag[1] != '0);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg   <= ST_IDLE;
      ma_reg      <= '0;
      mb_reg      <= '0;
      neg_reg     <= 1'b0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (Start_Sig) begin
            ma_reg    <= mag[0];
            mb_reg    <= mag[1];
            neg_reg   <= neg_next;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= skip_mul ? ST_SIGN : ST_MUL;
          end
        end
        ST_MUL: begin
          acc_reg <= acc_next;
          mb_reg  <= mb_next;
          cnt_reg <= cnt_next;
          if (last_iter) begin
            state_reg <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          product_reg <= neg_reg ? (PW'(0) - acc_reg) : acc_reg;
          done_reg    <= 1'b1;
          state_reg   <= ST_DONE;
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Busy_Sig = busy_reg;
  assign Done_Sig = done_reg;
  assign Product  = product_reg;

endmodule

// File: doc/booth_free_multiplier_module.md
Name: booth_free_multiplier_module

Overview:
- Sequential signed multiplier, WIDTH x WIDTH -> 2*WIDTH product, using magnitude shift-and-add with a final sign fix.
- Inverse-direction companion to the team's repeated-subtraction divider.
- Uses the same Start_Sig/Done_Sig handshake style, so a datapath controller can drive both interchangeably.

Parameters:
- WIDTH, 8, operand width in bits; operands and product are two's complement. Must be >= 2.

Ports:
- CLK  input  1  system clock, rising edge
- RSTn  input  1  asynchronous active-low reset
- Start_Sig  input  1  level request; launches an operation when high in IDLE
- Multiplicand  input  WIDTH  signed operand A, sampled in IDLE on launch edge
- Multiplier  input  WIDTH  signed operand B, sampled in IDLE on launch edge
- Busy_Sig  output  1  high from launch edge until Done_Sig deasserts
- Done_Sig  output  1  one-cycle completion pulse
- Product  output  2*WIDTH  signed A*B; valid while Done_Sig is high, held until the next Done_Sig

Behaviour:
- Reset (async, RSTn low):
  - State=IDLE.
  - Busy_Sig=0, Done_Sig=0, Product=0, all internal registers 0.
- IDLE, Start_Sig=1 at edge k (launch):
  - Latch mA=|A|, mB=|B| as WIDTH-bit unsigned magnitudes. -2^(WIDTH-1) maps to 2^(WIDTH-1), no overflow.
  - Latch neg=A[msb]^B[msb], clear acc (2*WIDTH), set cnt=0, Busy_Sig=1, go to MUL.
- IDLE, Start_Sig=0: stay in IDLE; outputs hold.
- MUL, one iteration per cycle, WIDTH cycles:
  - If mB[0]=1, acc <= acc + (mA << cnt).
  - Then mB <= mB>>1 and cnt++.
  - After the iteration with cnt=WIDTH-1, go to SIGN.
- SIGN (1 cycle):
  - Product <= neg ? -acc : acc, in 2*WIDTH-bit two's complement.
  - Done_Sig <= 1; go to DONE.
- DONE (1 cycle):
  - Done_Sig <= 0, Busy_Sig <= 0; go to IDLE.
- Latency:
  - Done_Sig is high during the cycle following edge k+WIDTH+1, i.e. WIDTH+2 edges after launch (10 for WIDTH=8).
  - Done_Sig is exactly one cycle wide.
- Start_Sig and operand changes while Busy_Sig=1: ignored; the operation completes with the latched operands.
- Start_Sig held high continuously: back-to-back operations. The next launch is at the first IDLE edge after DONE, giving a throughput of one result per WIDTH+3 cycles.
- Zero operand: result is 0 and neg is masked, so Product=0, never negative-zero artefacts. Full latency still applies unless EARLY_TERM_EN.
- Product range: the extreme (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits in signed 2*WIDTH bits. No saturation is needed.
- Reset mid-operation: immediate return to reset values; no partial Product is ever published.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in MUL, if the shifted mB==0 after an iteration (or mB==0 at launch), go directly to SIGN.
  - Latency becomes popcount-independent: (index of highest set bit of |B|)+3 edges, minimum 2 for B=0.
  - Busy_Sig and Done_Sig rules are unchanged.
- Undefined: fixed WIDTH+2 latency as above.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding constants ST_IDLE, ST_MUL, ST_SIGN, ST_DONE (2-bit);
  - counter width function CNT_W = clog2(WIDTH).
- Natural sub-module: twos_magnitude (combinational, WIDTH-bit signed in -> WIDTH-bit unsigned magnitude plus sign bit).
  - Instantiated twice at launch.
  - Reusable by the divider rework.

Test Plan:
- Reset then A=8'd7, B=8'd6, Start_Sig pulse 1 cycle -> Done_Sig high exactly 10 edges after launch, Product=16'd42, Busy_Sig low the following cycle.
- A=-8'd5 (8'hFB), B=8'd3 -> Product=16'hFFF1 (-15); A=-8'd128, B=-8'd128 -> Product=16'h4000; A=-8'd128, B=8'd127 -> 16'hC080.
- A=8'd0, B=-8'd9 -> Product=16'h0000. With MULT_EARLY_TERM_EN, A=8'd100, B=8'd1 -> Done_Sig after 3 edges, Product=16'd100.
- Start_Sig held high, operands changed every cycle during MUL -> results reflect only launch-edge operands; consecutive Done_Sig pulses spaced 11 cycles apart.
- RSTn asserted at MUL cycle 4 -> all outputs 0 asynchronously. After release, a new op 3*4 yields 12 with no residue from the aborted op.
- Random signed A,B (>=1000 pairs, WIDTH=8 and WIDTH=5) vs reference model -> Product always exact; Done_Sig never wider than 1 cycle.
